// File: rtl/shared_reg_pkg.sv
// Purpose: shared constants and types for the shared-register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_reg_pkg;

  // Two-state arbiter FSM: IDLE arbitrates, GRANT performs (or aborts) the write.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Optional completed-write counter width and its saturation value.
  localparam int                 WRCNT_W   = 16;
  localparam logic [WRCNT_W-1:0] WRCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Purpose: round-robin picker; first set req bit at or above ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; valid_o is low when no request is present.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  pick_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk the N_REQ candidates starting at ptr_i; the first hit wins.
  always_comb begin
    valid_o = 1'b0;
    pick_o  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        pick_o  = idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin arbiter owning one shared WIDTH-bit register (q/qbar); optional write counter under SHARED_REG_WRCNT_EN.
// Latency: req seen at edge t+1 -> gnt high, q loaded at edge t+2; at most one write per 2 cycles.
// Backpressure: requesters hold req/wdata until the cycle after gnt; dropping req during GRANT aborts the write.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar
`ifdef SHARED_REG_WRCNT_EN
  ,
  output logic [WRCNT_W-1:0]     wr_count
`endif
);

  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;

  logic             pick_vld;
  logic [ID_W-1:0]  pick;
  logic [WIDTH-1:0] wslice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign wslice[i] = wdata[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .pick_o  (pick)
  );

  // Next-state: IDLE issues a one-hot grant, GRANT commits or aborts the write and returns to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    q_d     = q_q;
    qbar_d  = qbar_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          gnt_d   = GNT_ONE << pick;
          gid_d   = pick;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[gid_q]) begin
          q_d    = wslice[gid_q];
          qbar_d = ~wslice[gid_q];
          ptr_d  = (gid_q == LAST_ID) ? '0 : gid_q + ID_W'(1);
        end
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, grant and shared register; reset loads qbar with all ones so qbar == ~q holds throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
      qbar_q  <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
      qbar_q  <= qbar_d;
    end
  end

  assign gnt      = gnt_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign q        = q_q;
  assign qbar     = qbar_q;

`ifdef SHARED_REG_WRCNT_EN
  logic               wr_done;
  logic [WRCNT_W-1:0] wr_cnt_q;

  assign wr_done = (state_q == ST_GRANT) && req[gid_q];

  // Count completed (non-aborted) writes, saturating at the top value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
    end else if (wr_done && (wr_cnt_q != WRCNT_MAX)) begin
      wr_cnt_q <= wr_cnt_q + WRCNT_W'(1);
    end
  end

  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Purpose: scoreboard bench for shared_reg_arbiter (default 4 x 8-bit); wr_count checked when SHARED_REG_WRCNT_EN is set.
// Latency: expected grants/writes are queued at drive time and retired as gnt and q appear.
// Backpressure: drivers follow the requester contract; one scenario aborts a write on purpose.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qbar;
`ifdef SHARED_REG_WRCNT_EN
  logic [15:0] wr_count;
`endif

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .grant_id (grant_id),
    .busy     (busy),
    .q        (q),
    .qbar     (qbar)
`ifdef SHARED_REG_WRCNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] qv;
    bit         wr;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         pending = 0;
  int         exp_wr = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a visible grant retires one scoreboard entry; the following cycle checks the register.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      exp_wr  = 0;
    end else if (gnt != 4'b0000) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_gnt", {28'd0, gnt}, 32'd0);
      end else begin
        cur = sb.pop_front();
        check_eq("gnt_onehot", {28'd0, gnt}, 32'd1 << cur.id);
        check_eq("grant_id", {30'd0, grant_id}, cur.id);
        check_eq("busy_in_grant", {31'd0, busy}, 32'd1);
        pending = 1;
      end
    end else if (pending) begin
      if (cur.wr) exp_wr++;
      check_eq("q_after_grant", {24'd0, q}, {24'd0, cur.qv});
      check_eq("qbar_after_grant", {24'd0, qbar}, {24'd0, ~cur.qv});
      check_eq("busy_after_grant", {31'd0, busy}, 32'd0);
      check_eq("grant_id_held", {30'd0, grant_id}, cur.id);
`ifdef SHARED_REG_WRCNT_EN
      check_eq("wr_count", {16'd0, wr_count}, exp_wr);
`endif
      pending = 0;
    end
  end

  task automatic push(input int id, input logic [7:0] qv, input bit wr);
    exp_t e;
    e.id = id;
    e.qv = qv;
    e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || pending) && n < 40) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, sb.size() + int'(pending), 0);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_q"}, {24'd0, q}, 32'h00);
    check_eq({tag, "_qbar"}, {24'd0, qbar}, 32'hFF);
    check_eq({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
`ifdef SHARED_REG_WRCNT_EN
    check_eq({tag, "_wr_count"}, {16'd0, wr_count}, 32'd0);
`endif
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;
    #2;
    reset_checks("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Round robin from ptr=0 with all four requesting: 0,1,2,3,0.
    @(negedge clk);
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    push(0, 8'h10, 1); push(1, 8'h11, 1); push(2, 8'h12, 1);
    push(3, 8'h13, 1); push(0, 8'h10, 1);
    repeat (10) @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_rr");

    // Single requester 2 (ptr is 1, so 2 is found after skipping 1).
    @(negedge clk);
    wdata[23:16] = 8'hA5;
    req = 4'b0100;
    push(2, 8'hA5, 1);
    repeat (2) @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_single");

    // Wrap: ptr=3 with req 1001 grants 3, then wraps to 0 rather than repeating 3.
    @(negedge clk);
    wdata[31:24] = 8'h33;
    wdata[7:0]   = 8'h40;
    req = 4'b1001;
    push(3, 8'h33, 1); push(0, 8'h40, 1);
    repeat (4) @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_wrap");

    // Abort: requester 1 drops req during GRANT; q stays 8'h40 and ptr stays 1.
    @(negedge clk);
    wdata[15:8] = 8'h77;
    req = 4'b0010;
    push(1, 8'h40, 0);
    @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_abort");

    // Requester 1 wins again against 2 because the abort left ptr at 1.
    @(negedge clk);
    wdata[23:16] = 8'h88;
    req = 4'b0110;
    push(1, 8'h77, 1);
    repeat (2) @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_regrant");

    // Reset mid-GRANT: the write is lost and outputs clear without a clock edge.
    @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    reset_checks("rst_mid_grant");
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // ptr was cleared by reset: req 1010 grants 1 (a stale ptr of 2 would pick 3).
    @(negedge clk);
    wdata[15:8]  = 8'h55;
    wdata[31:24] = 8'h66;
    req = 4'b1010;
    push(1, 8'h55, 1);
    repeat (2) @(posedge clk);
    #1 req = 4'b0000;
    drain("drain_post_rst");

    repeat (3) @(negedge clk);
    check_eq("idle_gnt", {28'd0, gnt}, 32'd0);
    check_eq("idle_q", {24'd0, q}, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-type storage register between N_REQ requesters.
- Grants one requester at a time and captures that requester's data into the register.
- Drives the stored value as q and its complement as qbar.
- Sits between several writer blocks and a single shared flip-flop bank; it is the only block that may load that bank.

Parameters:
- N_REQ, 4, number of requesters; must be >= 2.
- WIDTH, 8, data width of the shared register.
- ID_W, $clog2(N_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester write request; bit i belongs to requester i.
- wdata  input  N_REQ*WIDTH  flat write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
- gnt  output  N_REQ  registered one-hot grant.
- grant_id  output  ID_W  index of the current or last granted requester.
- busy  output  1  high while the FSM is in GRANT.
- q  output  WIDTH  shared register contents.
- qbar  output  WIDTH  bitwise complement of q, registered alongside q.

Behaviour:
- Reset: while rst=1, asynchronously force the following values.
  - gnt=0, grant_id=0, busy=0.
  - q=0, qbar={WIDTH{1'b1}}.
  - Round-robin pointer ptr=0; FSM state=IDLE.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If req is all zero, stay in IDLE with gnt=0.
  - Otherwise, pick the first set req bit searching upward from ptr, wrapping modulo N_REQ.
  - On the next edge: gnt <= onehot(pick), grant_id <= pick, busy <= 1, state <= GRANT.
- GRANT (exactly one cycle):
  - If req[grant_id]=1, do all of the following on the edge:
    - q <= wdata slice of grant_id.
    - qbar <= ~(that slice).
    - ptr <= (grant_id+1) mod N_REQ.
  - If req[grant_id]=0, treat it as an abort: q, qbar and ptr are unchanged.
  - In both cases on the edge: gnt <= 0, busy <= 0, state <= IDLE.
- Latency: req rising at edge t → gnt high after edge t+1 → q updated at edge t+2.
- Throughput: at most one write per 2 cycles. There are no back-to-back grants; IDLE always separates them.
- Requester contract:
  - Hold req and wdata stable from assertion until the cycle after gnt is seen.
  - Deassert req in the cycle after its grant, or it is re-arbitrated normally.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.
- Requests arriving during GRANT are ignored until the following IDLE cycle.
- Invariants:
  - qbar == ~q at every edge and during reset.
  - gnt is one-hot or zero.
  - grant_id holds its value after GRANT ends.
- Reset asserted mid-GRANT: the write is lost; all outputs and ptr return to reset values immediately.

Optional Feature:
- Macro: SHARED_REG_WRCNT_EN.
- When defined:
  - Add output wr_count [15:0].
  - wr_count is reset to 0 and increments by 1 on each completed (non-aborted) write.
  - It saturates at 16'hFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package shared_reg_pkg holds:
  - State encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - The wr_count width constant (16) and saturation value.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[N_REQ], ptr[ID_W].
  - Outputs: valid and pick[ID_W], using the wrap-around search.
  - Instantiated once by shared_reg_arbiter.
- All storage (ptr, FSM, q/qbar, gnt) lives in the top module.

Test Plan:
- Reset check: rst=1 mid-run → q=8'h00, qbar=8'hFF, gnt=4'b0000, busy=0, immediately without a clock edge.
- Single requester: req=4'b0100 with wdata slice2=8'hA5 → gnt=4'b0100 one cycle later; next edge q=8'hA5, qbar=8'h5A; then gnt=0.
- Round-robin fairness: req=4'b1111 held, slices 8'h10,8'h11,8'h12,8'h13 → grants in order 0,1,2,3,0; q follows 10,11,12,13,10, one write every 2 cycles.
- Wrap-around: after granting requester 3, req=4'b1001 → next grant is requester 0, not 3.
- Abort: requester 1 granted, req[1] dropped during GRANT → q unchanged, ptr unchanged, so requester 1 wins again when it re-requests alongside requester 2.
- Reset mid-GRANT and optional counter: with SHARED_REG_WRCNT_EN, 3 completed writes plus 1 abort → wr_count=3; rst during GRANT → q=0, wr_count=0, state IDLE.
